// File: rtl/cmd_serializer_pkg.sv
// Shared types and constants for the FX2 command-stream serializer.
package cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    CMD,
    DATA,
    GAP
  } state_t;

  localparam logic [7:0] CMD_REG_WRITE = 8'h01;
  localparam logic [7:0] CMD_SEQ_COUNT = 8'h04;
  localparam int         CMD_HDR_BYTES = 2;

endpackage

// File: rtl/cmd_serializer_if.sv
// Request handshake plus command-byte stream between a command source and the serializer.
interface cmd_serializer_if #(
  parameter int MAX_BYTES = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic [7:0]             req_cmd;
  logic [7:0]             req_len;
  logic [8*MAX_BYTES-1:0] req_payload;
  logic                   cmd_stall;
  logic                   cmd_wr;
  logic [7:0]             cmd_in;
  logic                   done;
  logic                   err;

  modport master (
    output req_valid, req_cmd, req_len, req_payload, cmd_stall,
    input  req_ready, cmd_wr, cmd_in, done, err
  );

  modport slave (
    input  req_valid, req_cmd, req_len, req_payload, cmd_stall,
    output req_ready, cmd_wr, cmd_in, done, err
  );
endinterface

// File: rtl/cmd_serializer.sv
// Serializes one request into LEN, CMD, payload bytes; first byte the cycle after accept,
// registered outputs, cmd_stall holds the pending byte, GAP_CYCLES idle cycles after each command.
module cmd_serializer
  import cmd_pkg::*;
#(
  parameter int MAX_BYTES  = 8,
  parameter int GAP_CYCLES = 2
) (
  input logic             fx2_clk,
  input logic             reset,
  cmd_serializer_if.slave bus
);

  localparam state_t     END_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;
  localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [7:0] LEN_LIMIT = 8'(MAX_BYTES);

  state_t                 state, state_n;
  logic [7:0]             len_q, cmd_q;
  logic [8*MAX_BYTES-1:0] payload_q;
  logic [7:0]             idx, idx_n;
  logic [7:0]             gcnt, gcnt_n;
  logic                   wr_q, wr_n;
  logic [7:0]             byte_q, byte_n;
  logic                   done_q, done_n;
  logic                   err_q, err_n;
  logic                   latch;
  logic [7:0]             pay_byte;

  always_comb begin
    pay_byte = 8'h00;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (idx == 8'(i)) pay_byte = payload_q[8*i +: 8];
    end
  end

  // State marks the last byte put on the bus; the next edge emits the following one.
  always_comb begin
    state_n = state;
    wr_n    = 1'b0;
    byte_n  = byte_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    idx_n   = idx;
    gcnt_n  = gcnt;
    latch   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_len > LEN_LIMIT) begin
            err_n = 1'b1;
          end else begin
            latch   = 1'b1;
            state_n = LEN;
            wr_n    = 1'b1;
            byte_n  = bus.req_len;
            idx_n   = 8'd0;
          end
        end
      end
      LEN: begin
        if (!bus.cmd_stall) begin
          state_n = CMD;
          wr_n    = 1'b1;
          byte_n  = cmd_q;
          done_n  = (len_q == 8'd0);
        end
      end
      CMD, DATA: begin
        if (idx == len_q) begin
          state_n = END_STATE;
          gcnt_n  = GAP_LOAD;
        end else if (!bus.cmd_stall) begin
          state_n = DATA;
          wr_n    = 1'b1;
          byte_n  = pay_byte;
          idx_n   = idx + 8'd1;
          done_n  = ((idx + 8'd1) == len_q);
        end
      end
      GAP: begin
        if (gcnt == 8'd0) state_n = IDLE;
        else gcnt_n = gcnt - 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge fx2_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      len_q     <= 8'd0;
      cmd_q     <= 8'd0;
      payload_q <= '0;
      idx       <= 8'd0;
      gcnt      <= 8'd0;
      wr_q      <= 1'b0;
      byte_q    <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      gcnt   <= gcnt_n;
      wr_q   <= wr_n;
      byte_q <= byte_n;
      done_q <= done_n;
      err_q  <= err_n;
      if (latch) begin
        len_q     <= bus.req_len;
        cmd_q     <= bus.req_cmd;
        payload_q <= bus.req_payload;
      end
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.cmd_wr    = wr_q;
  assign bus.cmd_in    = byte_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_cmd_serializer.sv
// Directed vector table plus randomized scoreboard run for cmd_serializer.
module tb_cmd_serializer;
  import cmd_pkg::*;

  localparam int MB = 8;
  localparam int GC = 2;

  logic fx2_clk = 1'b0;
  logic reset   = 1'b1;

  cmd_serializer_if #(.MAX_BYTES(MB)) bus ();

  cmd_serializer #(.MAX_BYTES(MB), .GAP_CYCLES(GC)) dut (
    .fx2_clk(fx2_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 fx2_clk = ~fx2_clk;

  int   total = 0;
  int   bad   = 0;
  logic stall_dir = 1'b0;
  logic stall_rnd = 1'b0;
  bit   mon_en = 1'b0;

  assign bus.cmd_stall = mon_en ? stall_rnd : stall_dir;

  typedef struct {
    logic [7:0]  cmd;
    logic [7:0]  len;
    logic [63:0] pay;
    int          stall_after;
    int          stall_n;
    bit          exp_err;
    int          exp_span;
    logic [7:0]  exp_last;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    bit         first;
    bit         last;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];
  int   pending_err = 0;
  logic mon_prev_stall;
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input vec_t v, input int i);
    logic [63:0] p;
    p = v.pay;
    if (i == 0) return v.len;
    if (i == 1) return v.cmd;
    if (i < int'(v.len) + CMD_HDR_BYTES) return p[8*(i-2) +: 8];
    return 8'hxx;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] got[$];
    int         last_cyc = -1;
    int         done_cyc = -1;
    int         rdy_cyc  = -1;
    int         stalls   = 0;
    logic [7:0] done_byte = 8'h00;
    @(negedge fx2_clk);
    chk({tag, "_ready_in"}, bus.req_ready, 1);
    bus.req_valid   = 1'b1;
    bus.req_cmd     = v.cmd;
    bus.req_len     = v.len;
    bus.req_payload = v.pay;
    stall_dir       = 1'b0;
    @(negedge fx2_clk);
    bus.req_valid   = 1'b0;
    bus.req_cmd     = 8'($urandom);
    bus.req_len     = 8'($urandom);
    bus.req_payload = {$urandom, $urandom};
    if (v.exp_err) begin
      chk({tag, "_err"}, bus.err, 1);
      chk({tag, "_err_wr"}, bus.cmd_wr, 0);
      chk({tag, "_err_ready"}, bus.req_ready, 1);
      @(negedge fx2_clk);
      chk({tag, "_err_pulse"}, bus.err, 0);
      chk({tag, "_err_wr2"}, bus.cmd_wr, 0);
      return;
    end
    for (int c = 0; c < 64; c++) begin
      if (bus.cmd_wr) begin
        got.push_back(bus.cmd_in);
        last_cyc = c;
      end
      if (bus.done) begin
        done_cyc  = c;
        done_byte = bus.cmd_in;
      end
      if (bus.req_ready) begin
        rdy_cyc = c;
        break;
      end
      if (got.size() == v.stall_after && stalls < v.stall_n) begin
        stall_dir = 1'b1;
        stalls++;
      end else begin
        stall_dir = 1'b0;
      end
      @(negedge fx2_clk);
    end
    stall_dir = 1'b0;
    chk({tag, "_timeout"}, rdy_cyc >= 0, 1);
    chk({tag, "_count"}, got.size(), int'(v.len) + CMD_HDR_BYTES);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), got[i], exp_byte(v, i));
    chk({tag, "_span"}, last_cyc + 1, v.exp_span);
    chk({tag, "_done_cyc"}, done_cyc, last_cyc);
    chk({tag, "_done_byte"}, done_byte, v.exp_last);
    chk({tag, "_gap"}, rdy_cyc - last_cyc - 1, GC);
  endtask

  // Scoreboard for the random phase; also drives the random stall.
  always @(negedge fx2_clk) begin
    if (mon_en) begin
      mon_prev_stall = bus.cmd_stall;
      if (bus.cmd_wr) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rnd_extra_byte: got %0h expected no byte", bus.cmd_in);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rnd_byte", bus.cmd_in, mon_e.b);
          chk("rnd_done", bus.done, mon_e.last);
          if (mon_prev_stall) chk("rnd_stall_hold", mon_e.first, 1);
        end
      end else if (bus.done) begin
        total++;
        bad++;
        $display("FAIL rnd_done_idle: got done=1 with cmd_wr=0 expected done=0");
      end
      if (bus.err) begin
        if (pending_err > 0) pending_err--;
        else begin
          total++;
          bad++;
          $display("FAIL rnd_err: got err=1 expected err=0");
        end
      end
      stall_rnd = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  l, c;
    logic [63:0] p;
    int          w, n, extra;

    vecs[0] = '{CMD_SEQ_COUNT, 8'd5, 64'h00000002_40000000, 0, 0, 1'b0, 7,  8'h02};
    vecs[1] = '{CMD_REG_WRITE, 8'd1, 64'h01,                0, 0, 1'b0, 3,  8'h01};
    vecs[2] = '{8'hAA,         8'd0, 64'hDEAD,              0, 0, 1'b0, 2,  8'hAA};
    vecs[3] = '{8'h55,         8'd9, 64'h1234,              0, 0, 1'b1, 0,  8'h00};
    vecs[4] = '{CMD_SEQ_COUNT, 8'd5, 64'h00000002_40000000, 4, 3, 1'b0, 10, 8'h02};
    vecs[5] = '{8'h7F,         8'd8, 64'h88776655_44332211, 1, 1, 1'b0, 11, 8'h88};
    vecs[6] = '{8'h3C,         8'd8, 64'hF0E1D2C3_B4A59687, 9, 2, 1'b0, 12, 8'hF0};
    vecs[7] = '{8'h12,         8'd2, 64'h0000BBAA,          4, 2, 1'b0, 4,  8'hBB};

    bus.req_valid   = 1'b0;
    bus.req_cmd     = 8'h00;
    bus.req_len     = 8'h00;
    bus.req_payload = '0;

    repeat (2) @(negedge fx2_clk);
    chk("rst_wr", bus.cmd_wr, 0);
    chk("rst_cmd_in", bus.cmd_in, 8'h00);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_ready", bus.req_ready, 1);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while data byte 1 is on the bus.
    @(negedge fx2_clk);
    bus.req_valid   = 1'b1;
    bus.req_cmd     = CMD_SEQ_COUNT;
    bus.req_len     = 8'd5;
    bus.req_payload = 64'h00000002_40000000;
    @(negedge fx2_clk);
    bus.req_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      if (bus.cmd_wr) n++;
      if (n < 4) @(negedge fx2_clk);
    end
    chk("midrst_reach", n, 4);
    reset = 1'b1;
    #1;
    chk("midrst_wr", bus.cmd_wr, 0);
    chk("midrst_ready", bus.req_ready, 1);
    chk("midrst_done", bus.done, 0);
    @(negedge fx2_clk);
    reset = 1'b0;
    extra = 0;
    repeat (10) begin
      @(negedge fx2_clk);
      if (bus.cmd_wr) extra++;
    end
    chk("midrst_residual", extra, 0);
    chk("midrst_ready_after", bus.req_ready, 1);
    run_vec(vecs[1], "post_rst");

    // Random requests against the queue model.
    mon_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      l = 8'($urandom_range(0, 9));
      c = 8'($urandom);
      p = {$urandom, $urandom};
      @(negedge fx2_clk);
      bus.req_valid   = 1'b1;
      bus.req_cmd     = c;
      bus.req_len     = l;
      bus.req_payload = p;
      w = 0;
      while (!bus.req_ready && w < 200) begin
        @(negedge fx2_clk);
        w++;
      end
      if (w >= 200) begin
        chk("rnd_ready_timeout", w, 0);
        break;
      end
      @(posedge fx2_clk);
      if (l > 8'(MB)) begin
        pending_err++;
      end else begin
        exp_q.push_back('{l, 1'b1, 1'b0});
        exp_q.push_back('{c, 1'b0, (l == 8'd0)});
        for (int i = 0; i < int'(l); i++)
          exp_q.push_back('{p[8*i +: 8], 1'b0, (i == int'(l) - 1)});
      end
      @(negedge fx2_clk);
      bus.req_valid   = 1'b0;
      bus.req_cmd     = 8'($urandom);
      bus.req_len     = 8'($urandom);
      bus.req_payload = {$urandom, $urandom};
      repeat ($urandom_range(0, 2)) @(negedge fx2_clk);
    end
    w = 0;
    while ((exp_q.size() != 0 || !bus.req_ready) && w < 500) begin
      @(negedge fx2_clk);
      w++;
    end
    @(negedge fx2_clk);
    mon_en = 1'b0;
    chk("rnd_drain", exp_q.size(), 0);
    chk("rnd_err_pending", pending_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
